guess_commit_ctrl: RTL and testbench
====================================

# guess_commit_ctrl

Sequencer that commits an entered guess to the shared board RAM and scores it against the secret. On `start` it snapshots guess and secret, writes the guess pins into the guess region, runs a serial green pass and a serial yellow pass, then writes the two hint counts into the hint region. It sits between the game-state FSM and the board RAM, which it shares with the renderer through a request/grant handshake.

## Interface
- `MAX_PINS`, default 20: pin slots; equals `max_pins_count`.
- `MAX_GUESSES`, default 99: guess rows; equals `max_guesses`.
- `COLOR_W`, default 8: pin colour width.
- `ADDR_W`, default 12: RAM address width.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: commit request; sampled only in IDLE.
- `pins_count` in 8: active pins P.
- `guessed_count` in 8: row index G to write.
- `guess` in MAX_PINS*COLOR_W: flattened current guess; pin i is at bits [i*COLOR_W +: COLOR_W].
- `secret` in MAX_PINS*COLOR_W: flattened secret, same layout.
- `busy` out 1: high from the cycle after start acceptance through DONE.
- `done` out 1: one-cycle pulse in DONE.
- `overflow` out 1: valid with `done`; the commit was rejected.
- `green` out 8: exact-position matches; holds until the next accepted start.
- `yellow` out 8: colour-only matches; holds until the next accepted start.
- `ram_req` out 1: RAM access request.
- `ram_gnt` in 1: a write is accepted on any cycle where `ram_req` and `ram_gnt` are both high.
- `ram_we` out 1: equals `ram_req`; the block only writes.
- `ram_addr` out ADDR_W: write address.
- `ram_wdata` out COLOR_W: write data.

## Operation
- Clamp: P_eff = min(P, MAX_PINS). Overflow condition: G ≥ MAX_GUESSES.
- States, with transitions below:
  - IDLE: on `start`, latch guess, secret, P_eff and G; clear green, yellow, analyzed_guess and analyzed_secret. Go to CHECK.
  - CHECK: if overflow, go to DONE with `overflow`=1 and perform no writes. If P_eff=0, go to HINT_G. Otherwise go to UPLOAD with i=0.
  - UPLOAD: `ram_req`=1, addr = G*P_eff + i, data = guess[i].
    - On grant: i++. After pin P_eff-1 is granted, go to GREEN with i=0.
    - Without grant: stall, holding addr and data.
  - GREEN: one pin per cycle. If guess[i]==secret[i], set both analyzed bits and green++. After pin P_eff-1, go to YELLOW with i=0, j=0.
  - YELLOW: one (i,j) pair per cycle.
    - If analyzed_guess[i]: advance i.
    - Else if !analyzed_secret[j] and secret[j]==guess[i]: set analyzed_secret[j] and analyzed_guess[i], yellow++, advance i.
    - Else if j==P_eff-1: advance i.
    - Else: j++.
    - Advancing i resets j to 0. After i=P_eff-1 advances, go to HINT_G.
  - HINT_G: write green at `ram_hints_offset` + 2G; on grant go to HINT_Y.
  - HINT_Y: write yellow at `ram_hints_offset` + 2G + 1; on grant go to DONE.
  - DONE: `done`=1, then IDLE.
- Arithmetic: address products and sums are computed at ADDR_W bits; maximum address is 2177. Counters are 8 bits; green + yellow ≤ P_eff.
- `ram_req` is low in every state except UPLOAD, HINT_G and HINT_Y. `ram_gnt` is ignored when `ram_req` is low.
- `start` during `busy` is ignored. Input changes after acceptance have no effect because the inputs are snapshotted.

## Timing
- Reset values: `busy`, `done`, `overflow`, `ram_req` and `ram_we` are 0; `ram_addr`, `ram_wdata`, `green` and `yellow` are 0; state is IDLE.
- Reset mid-operation drops `ram_req` immediately (asynchronous) and abandons the commit. RAM contents already written are not rolled back.
- Latency with `ram_gnt` tied high, counted as cycles from the start-sampling edge to `done` high: 1 (CHECK) + P_eff + P_eff + Y + 2, where Y is the number of YELLOW cycles. Each grant-low cycle in a write state adds one cycle.
- Worst-case Y = P_eff². An overflow commit reaches `done` 2 cycles after start.
- `green` and `yellow` are valid when `done` is high and stay stable while not `busy`.

## Configuration
- `GUESS_COMMIT_HINT_WRITE_EN` defined: HINT_G and HINT_Y exist and the hint region is written as described.
- `GUESS_COMMIT_HINT_WRITE_EN` undefined: YELLOW (or CHECK when P_eff=0) goes directly to DONE. No hint-region writes occur and latency drops by 2. `green` and `yellow` outputs are unchanged.

## Structure
- Shared package:
  - state enum typedef `GC_STATE_NAME`
  - `ram_hints_offset`, `max_pins_count` and `max_guesses` (already shared)
  - hint stride constant (2)
- Sub-module `pin_match_scanner`: owns the i/j counters, both analyzed vectors and the green/yellow counters, with start/step/finished handshake to the FSM. The RAM-facing FSM stays in `guess_commit_ctrl`.

## Test plan
- P=4, G=0, secret {1,2,3,4}, guess {1,2,3,4}, gnt high → green=4, yellow=0; writes at 0..3 then 1980=4, 1981=0; `done` 15 cycles after start.
- Same secret, guess {4,3,2,1}, G=5 → green=0, yellow=4; Y=10; guess writes at 20..23; hints at 1990/1991; `done` 21 cycles after start (19 without the macro).
- Secret {1,1,2,2}, guess {1,2,1,3} → green=1, yellow=2; no double-counting of secret slot 0.
- `ram_gnt` low for 3 cycles during UPLOAD pin 2 → addr and data held stable; `done` delayed exactly 3 cycles.
- G=99 → no `ram_req`; `done` and `overflow` pulse 2 cycles after start; `start` pulsed while `busy` is ignored.
- Assert `reset` during YELLOW → `ram_req`, `busy` and outputs go to 0 immediately; a subsequent start with P=0 gives green=yellow=0 and hints written at 1980+2G.

Source files
------------

// File: rtl/guess_commit_ctrl_pkg.sv
// Shared constants and state encoding for the guess commit sequencer.
package guess_commit_ctrl_pkg;

    localparam int unsigned max_pins_count   = 20;
    localparam int unsigned max_guesses      = 99;
    localparam int unsigned ram_hints_offset = max_pins_count * max_guesses;
    localparam int unsigned hint_stride      = 2;

    localparam int unsigned GC_STATE_W = 4;

    typedef logic [GC_STATE_W-1:0] GC_STATE_NAME;

    localparam GC_STATE_NAME GC_IDLE   = 4'd0;
    localparam GC_STATE_NAME GC_CHECK  = 4'd1;
    localparam GC_STATE_NAME GC_REJECT = 4'd2;
    localparam GC_STATE_NAME GC_UPLOAD = 4'd3;
    localparam GC_STATE_NAME GC_GREEN  = 4'd4;
    localparam GC_STATE_NAME GC_YELLOW = 4'd5;
    localparam GC_STATE_NAME GC_HINT_G = 4'd6;
    localparam GC_STATE_NAME GC_HINT_Y = 4'd7;
    localparam GC_STATE_NAME GC_DONE   = 4'd8;

    // Clamp a requested pin count to the number of physical pin slots.
    function automatic logic [7:0] clamp_pins(input logic [7:0] p, input logic [7:0] lim);
        return (p > lim) ? lim : p;
    endfunction

endpackage

// File: rtl/guess_commit_ctrl_pin_match_scanner.sv
// Serial green/yellow scorer: walks the pins one step per cycle under FSM control.
module pin_match_scanner
    import guess_commit_ctrl_pkg::*;
#(
    parameter int unsigned MAX_PINS = max_pins_count,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        step,
    input  logic                        phase,
    input  logic [IDX_W-1:0]            last_idx,
    input  logic [MAX_PINS*COLOR_W-1:0] guess,
    input  logic [MAX_PINS*COLOR_W-1:0] secret,
    output logic                        last_c,
    output logic [7:0]                  green,
    output logic [7:0]                  yellow
);

    logic [COLOR_W-1:0]  guess_pin  [MAX_PINS];
    logic [COLOR_W-1:0]  secret_pin [MAX_PINS];
    logic [IDX_W-1:0]    idx_i;
    logic [IDX_W-1:0]    idx_j;
    logic [MAX_PINS-1:0] analyzed_guess;
    logic [MAX_PINS-1:0] analyzed_secret;

    logic at_last_i_c;
    logic at_last_j_c;
    logic green_hit_c;
    logic yellow_hit_c;
    logic advance_c;

    for (genvar k = 0; k < int'(MAX_PINS); k++) begin : g_unpack
        assign guess_pin[k]  = guess[k*COLOR_W +: COLOR_W];
        assign secret_pin[k] = secret[k*COLOR_W +: COLOR_W];
    end

    // Per-step match decisions for the current (i, j) pair.
    always_comb begin
        at_last_i_c  = (idx_i == last_idx);
        at_last_j_c  = (idx_j == last_idx);
        green_hit_c  = (guess_pin[idx_i] == secret_pin[idx_i]);
        yellow_hit_c = !analyzed_guess[idx_i] && !analyzed_secret[idx_j] &&
                       (secret_pin[idx_j] == guess_pin[idx_i]);
        advance_c    = phase ? (analyzed_guess[idx_i] || yellow_hit_c || at_last_j_c) : 1'b1;
        last_c       = step && at_last_i_c && advance_c;
    end

    // Counters and analyzed flags; cleared on commit acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_i           <= '0;
            idx_j           <= '0;
            analyzed_guess  <= '0;
            analyzed_secret <= '0;
            green           <= 8'd0;
            yellow          <= 8'd0;
        end else if (clear) begin
            idx_i           <= '0;
            idx_j           <= '0;
            analyzed_guess  <= '0;
            analyzed_secret <= '0;
            green           <= 8'd0;
            yellow          <= 8'd0;
        end else if (step) begin
            if (!phase) begin
                if (green_hit_c) begin
                    analyzed_guess[idx_i]  <= 1'b1;
                    analyzed_secret[idx_i] <= 1'b1;
                    green                  <= green + 8'd1;
                end
            end else if (yellow_hit_c) begin
                analyzed_guess[idx_i]  <= 1'b1;
                analyzed_secret[idx_j] <= 1'b1;
                yellow                 <= yellow + 8'd1;
            end
            if (advance_c) begin
                idx_i <= at_last_i_c ? '0 : idx_i + IDX_W'(1);
                idx_j <= '0;
            end else begin
                idx_j <= idx_j + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/guess_commit_ctrl.sv
// Guess commit sequencer: uploads the guess row, scores it, writes the hints.
// Optional build macro GUESS_COMMIT_HINT_WRITE_EN enables the hint-region writes.
module guess_commit_ctrl
    import guess_commit_ctrl_pkg::*;
#(
    parameter int unsigned MAX_PINS    = max_pins_count,
    parameter int unsigned MAX_GUESSES = max_guesses,
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [7:0]                  pins_count,
    input  logic [7:0]                  guessed_count,
    input  logic [MAX_PINS*COLOR_W-1:0] guess,
    input  logic [MAX_PINS*COLOR_W-1:0] secret,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [7:0]                  green,
    output logic [7:0]                  yellow,
    output logic                        ram_req,
    input  logic                        ram_gnt,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [COLOR_W-1:0]          ram_wdata
);

    localparam int unsigned IDX_W = (MAX_PINS > 1) ? $clog2(MAX_PINS) : 1;

`ifdef GUESS_COMMIT_HINT_WRITE_EN
    localparam GC_STATE_NAME POST_SCAN = GC_HINT_G;
`else
    localparam GC_STATE_NAME POST_SCAN = GC_DONE;
`endif

    GC_STATE_NAME state;
    GC_STATE_NAME next_state;

    logic [MAX_PINS*COLOR_W-1:0] guess_q;
    logic [MAX_PINS*COLOR_W-1:0] secret_q;
    logic [7:0]                  p_eff_q;
    logic [7:0]                  g_q;
    logic [ADDR_W-1:0]           row_base_q;
    logic [ADDR_W-1:0]           hint_base_q;
    logic [IDX_W-1:0]            upl_idx;
    logic [IDX_W-1:0]            upl_idx_d;
    logic [COLOR_W-1:0]          guess_pin [MAX_PINS];

    logic                        accept_c;
    logic [7:0]                  p_eff_c;
    logic [IDX_W-1:0]            last_idx;
    logic                        scan_step;
    logic                        scan_phase;
    logic                        scan_last_c;

    logic                        busy_d;
    logic                        done_d;
    logic                        overflow_d;
    logic                        ram_req_d;
    logic [ADDR_W-1:0]           ram_addr_d;
    logic [COLOR_W-1:0]          ram_wdata_d;

    for (genvar k = 0; k < int'(MAX_PINS); k++) begin : g_unpack
        assign guess_pin[k] = guess_q[k*COLOR_W +: COLOR_W];
    end

    assign accept_c = (state == GC_IDLE) && start;
    assign p_eff_c  = clamp_pins(pins_count, 8'(MAX_PINS));
    assign last_idx = IDX_W'(p_eff_q - 8'd1);
    assign ram_we   = ram_req;

    pin_match_scanner #(
        .MAX_PINS (MAX_PINS),
        .COLOR_W  (COLOR_W),
        .IDX_W    (IDX_W)
    ) u_scanner (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept_c),
        .step     (scan_step),
        .phase    (scan_phase),
        .last_idx (last_idx),
        .guess    (guess_q),
        .secret   (secret_q),
        .last_c   (scan_last_c),
        .green    (green),
        .yellow   (yellow)
    );

    // Next state plus next values of the registered outputs.
    always_comb begin
        next_state  = state;
        upl_idx_d   = upl_idx;
        scan_step   = 1'b0;
        scan_phase  = 1'b0;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;

        case (state)
            GC_IDLE: begin
                if (start) next_state = GC_CHECK;
            end
            GC_CHECK: begin
                if (g_q >= 8'(MAX_GUESSES)) begin
                    next_state = GC_REJECT;
                end else if (p_eff_q == 8'd0) begin
                    next_state = POST_SCAN;
                end else begin
                    next_state = GC_UPLOAD;
                    upl_idx_d  = '0;
                end
            end
            // Rejected commits take a fixed extra cycle before the done pulse.
            GC_REJECT: next_state = GC_DONE;
            GC_UPLOAD: begin
                if (ram_gnt) begin
                    if (upl_idx == last_idx) begin
                        next_state = GC_GREEN;
                        upl_idx_d  = '0;
                    end else begin
                        upl_idx_d = upl_idx + IDX_W'(1);
                    end
                end
            end
            GC_GREEN: begin
                scan_step = 1'b1;
                if (scan_last_c) next_state = GC_YELLOW;
            end
            GC_YELLOW: begin
                scan_step  = 1'b1;
                scan_phase = 1'b1;
                if (scan_last_c) next_state = POST_SCAN;
            end
            GC_HINT_G: begin
                if (ram_gnt) next_state = GC_HINT_Y;
            end
            GC_HINT_Y: begin
                if (ram_gnt) next_state = GC_DONE;
            end
            GC_DONE: next_state = GC_IDLE;
            default: next_state = GC_IDLE;
        endcase

        case (next_state)
            GC_UPLOAD: begin
                ram_addr_d  = row_base_q + ADDR_W'(upl_idx_d);
                ram_wdata_d = guess_pin[upl_idx_d];
            end
            GC_HINT_G: begin
                ram_addr_d  = hint_base_q;
                ram_wdata_d = COLOR_W'(green);
            end
            GC_HINT_Y: begin
                ram_addr_d  = hint_base_q + ADDR_W'(1);
                ram_wdata_d = COLOR_W'(yellow);
            end
            default: ;
        endcase

        ram_req_d  = (next_state == GC_UPLOAD) || (next_state == GC_HINT_G) ||
                     (next_state == GC_HINT_Y);
        busy_d     = (next_state != GC_IDLE);
        done_d     = (next_state == GC_DONE);
        overflow_d = (next_state == GC_DONE) && (state == GC_REJECT);
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= GC_IDLE;
            upl_idx     <= '0;
            guess_q     <= '0;
            secret_q    <= '0;
            p_eff_q     <= 8'd0;
            g_q         <= 8'd0;
            row_base_q  <= '0;
            hint_base_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            ram_req     <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            state     <= next_state;
            upl_idx   <= upl_idx_d;
            busy      <= busy_d;
            done      <= done_d;
            overflow  <= overflow_d;
            ram_req   <= ram_req_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            if (accept_c) begin
                guess_q     <= guess;
                secret_q    <= secret;
                p_eff_q     <= p_eff_c;
                g_q         <= guessed_count;
                row_base_q  <= ADDR_W'(guessed_count) * ADDR_W'(p_eff_c);
                hint_base_q <= ADDR_W'(ram_hints_offset) +
                               ADDR_W'(guessed_count) * ADDR_W'(hint_stride);
            end
        end
    end

endmodule

// File: tb/tb_guess_commit_ctrl.sv
// Randomized self-checking bench for guess_commit_ctrl against a scoring model.
module tb_guess_commit_ctrl;

    localparam int NP   = 20;
    localparam int CW   = 8;
    localparam int AW   = 12;
    localparam int HOFF = 1980;
`ifdef GUESS_COMMIT_HINT_WRITE_EN
    localparam int HINTS = 1;
`else
    localparam int HINTS = 0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       pins_count;
    logic [7:0]       guessed_count;
    logic [NP*CW-1:0] guess;
    logic [NP*CW-1:0] secret;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [7:0]       green;
    logic [7:0]       yellow;
    logic             ram_req;
    logic             ram_gnt;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [CW-1:0]    ram_wdata;

    guess_commit_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pins_count    (pins_count),
        .guessed_count (guessed_count),
        .guess         (guess),
        .secret        (secret),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .green         (green),
        .yellow        (yellow),
        .ram_req       (ram_req),
        .ram_gnt       (ram_gnt),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Grant driver: 0 = always grant, 1 = random, 2 = withhold 3 cycles at one address.
    int            gnt_mode   = 0;
    int            stall_left = 0;
    logic [AW-1:0] stall_addr = '0;
    initial ram_gnt = 1'b0;
    always @(negedge clk) begin
        case (gnt_mode)
            1: ram_gnt = ($urandom_range(0, 3) != 0);
            2: begin
                if (ram_req && ram_addr == stall_addr && stall_left > 0) begin
                    ram_gnt = 1'b0;
                    stall_left--;
                end else begin
                    ram_gnt = 1'b1;
                end
            end
            default: ram_gnt = 1'b1;
        endcase
    end

    // RAM-side monitor: records accepted writes, counts stalls, checks held bus.
    int            wr_q[$];
    int            stall_cnt = 0;
    int            req_cnt   = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [CW-1:0] prev_data;
    always @(posedge clk) begin
        if (!reset) begin
            if (ram_req) begin
                req_cnt++;
                check("we_eq_req", 32'(ram_we), 32'(1));
            end
            if (prev_stall) begin
                check("stall_addr_held", 32'(ram_addr), 32'(prev_addr));
                check("stall_data_held", 32'(ram_wdata), 32'(prev_data));
            end
            if (ram_req && ram_gnt) wr_q.push_back((int'(ram_addr) << 8) | int'(ram_wdata));
            if (ram_req && !ram_gnt) stall_cnt++;
            prev_stall = ram_req && !ram_gnt;
            prev_addr  = ram_addr;
            prev_data  = ram_wdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Scoring model: greens by position, yellows by per-colour leftover counts,
    // yellow-pass cycles from the first-free-secret-slot search order.
    function automatic void ref_model(input int p_in, input logic [NP*CW-1:0] gv,
                                      input logic [NP*CW-1:0] sv, output int peff,
                                      output int grn, output int yel, output int ycyc);
        int hg[256];
        int hs[256];
        bit used[NP];
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        bit found;
        peff = (p_in > NP) ? NP : p_in;
        grn  = 0;
        yel  = 0;
        ycyc = 0;
        for (int c = 0; c < 256; c++) begin
            hg[c] = 0;
            hs[c] = 0;
        end
        for (int k = 0; k < NP; k++) used[k] = 1'b0;
        for (int k = 0; k < peff; k++) begin
            a = gv[k*CW +: CW];
            b = sv[k*CW +: CW];
            if (a == b) begin
                grn++;
                used[k] = 1'b1;
            end else begin
                hg[int'(a)]++;
                hs[int'(b)]++;
            end
        end
        for (int c = 0; c < 256; c++) yel += (hg[c] < hs[c]) ? hg[c] : hs[c];
        for (int i = 0; i < peff; i++) begin
            a = gv[i*CW +: CW];
            if (a == sv[i*CW +: CW]) begin
                ycyc += 1;
            end else begin
                found = 1'b0;
                for (int j = 0; j < peff && !found; j++) begin
                    if (!used[j] && sv[j*CW +: CW] == a) begin
                        used[j] = 1'b1;
                        ycyc += j + 1;
                        found = 1'b1;
                    end
                end
                if (!found) ycyc += peff;
            end
        end
    endfunction

    function automatic logic [NP*CW-1:0] rand_pins(input int max_col);
        logic [NP*CW-1:0] v;
        for (int k = 0; k < NP; k++) v[k*CW +: CW] = CW'($urandom_range(0, max_col));
        return v;
    endfunction

    function automatic logic [NP*CW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [NP*CW-1:0] v;
        v = rand_pins(255);
        v[0*CW +: CW] = CW'(a);
        v[1*CW +: CW] = CW'(b);
        v[2*CW +: CW] = CW'(c);
        v[3*CW +: CW] = CW'(d);
        return v;
    endfunction

    // One commit: drive start, measure latency, compare scores and RAM writes.
    // abort_at != 0 asserts reset that many cycles after acceptance instead.
    task automatic run_commit(input string name, input int p, input int g,
                              input logic [NP*CW-1:0] gv, input logic [NP*CW-1:0] sv,
                              input int abort_at);
        int peff;
        int grn;
        int yel;
        int ycyc;
        int exp_lat;
        int cyc;
        int exp_w[$];
        bit ovf;
        ref_model(p, gv, sv, peff, grn, yel, ycyc);
        ovf = (g >= 99);
        if (!ovf) begin
            for (int k = 0; k < peff; k++) exp_w.push_back(((g * peff + k) << 8) | int'(gv[k*CW +: CW]));
            if (HINTS != 0) begin
                exp_w.push_back(((HOFF + 2 * g) << 8) | grn);
                exp_w.push_back(((HOFF + 2 * g + 1) << 8) | yel);
            end
        end
        exp_lat = ovf ? 2 : (1 + 2 * peff + ycyc + 2 * HINTS);

        @(negedge clk);
        pins_count    = 8'(p);
        guessed_count = 8'(g);
        guess         = gv;
        secret        = sv;
        start         = 1'b1;
        wr_q.delete();
        stall_cnt = 0;
        req_cnt   = 0;
        @(posedge clk);
        #1;
        start         = 1'b0;
        guess         = rand_pins(255);
        secret        = rand_pins(255);
        pins_count    = 8'($urandom_range(0, 255));
        guessed_count = 8'($urandom_range(0, 255));
        check({name, ":busy_after_start"}, 32'(busy), 32'(1));

        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == 1);
            if (abort_at != 0 && cyc == abort_at) begin
                start = 1'b0;
                #1;
                reset = 1'b1;
                #1;
                check({name, ":rst_ram_req"}, 32'(ram_req), 32'(0));
                check({name, ":rst_busy"}, 32'(busy), 32'(0));
                check({name, ":rst_green"}, 32'(green), 32'(0));
                check({name, ":rst_yellow"}, 32'(yellow), 32'(0));
                check({name, ":rst_addr"}, 32'(ram_addr), 32'(0));
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        start = 1'b0;
        check({name, ":done_seen"}, 32'(done), 32'(1));
        check({name, ":latency"}, 32'(cyc), 32'(exp_lat + stall_cnt));
        check({name, ":overflow"}, 32'(overflow), 32'(ovf));
        check({name, ":green"}, 32'(green), ovf ? 32'(0) : 32'(grn));
        check({name, ":yellow"}, 32'(yellow), ovf ? 32'(0) : 32'(yel));
        if (ovf) check({name, ":no_req"}, 32'(req_cnt), 32'(0));

        @(posedge clk);
        #1;
        check({name, ":done_pulse"}, 32'(done), 32'(0));
        check({name, ":idle_busy"}, 32'(busy), 32'(0));
        check({name, ":green_hold"}, 32'(green), ovf ? 32'(0) : 32'(grn));
        check({name, ":n_writes"}, 32'(wr_q.size()), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++)
            check({name, ":write(addr<<8|data)"}, 32'(wr_q[k]), 32'(exp_w[k]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        int g;
        reset         = 1'b1;
        start         = 1'b0;
        pins_count    = 8'd0;
        guessed_count = 8'd0;
        guess         = '0;
        secret        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_overflow", 32'(overflow), 32'(0));
        check("reset_ram_req", 32'(ram_req), 32'(0));
        check("reset_ram_we", 32'(ram_we), 32'(0));
        check("reset_ram_addr", 32'(ram_addr), 32'(0));
        check("reset_ram_wdata", 32'(ram_wdata), 32'(0));
        check("reset_green", 32'(green), 32'(0));
        check("reset_yellow", 32'(yellow), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        gnt_mode = 0;
        run_commit("exact", 4, 0, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0);
        run_commit("reversed", 4, 5, pack4(4, 3, 2, 1), pack4(1, 2, 3, 4), 0);
        run_commit("dup_secret", 4, 7, pack4(1, 2, 1, 3), pack4(1, 1, 2, 2), 0);

        gnt_mode   = 2;
        stall_addr = AW'(3 * 4 + 2);
        stall_left = 3;
        run_commit("stall_pin2", 4, 3, pack4(5, 6, 7, 8), pack4(8, 6, 5, 9), 0);
        check("stall_pin2:stall_cycles", 32'(stall_cnt), 32'(3));
        gnt_mode = 0;

        run_commit("overflow", 4, 99, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0);
        run_commit("max_row", 20, 98, rand_pins(3), rand_pins(3), 0);
        run_commit("clamp", 200, 2, rand_pins(2), rand_pins(2), 0);

        run_commit("abort_yellow", 4, 5, pack4(4, 3, 2, 1), pack4(1, 2, 3, 4), 12);
        run_commit("after_reset_p0", 0, 42, rand_pins(3), rand_pins(3), 0);

        for (int t = 0; t < 40; t++) begin
            gnt_mode = (t % 3 == 0) ? 0 : 1;
            p = $urandom_range(0, 22);
            g = ($urandom_range(0, 7) == 0) ? $urandom_range(99, 255) : $urandom_range(0, 98);
            run_commit($sformatf("rand%0d", t), p, g, rand_pins(3), rand_pins(3), 0);
        end
        gnt_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
